// File: rtl/ping_echo_timer_pkg.sv
// Shared types and default timing constants for the ping/echo time-of-flight timer.
// All counts are in cycles of the 150 MHz system clock.
package ping_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TX,
        BLANK,
        LISTEN
    } state_t;

    localparam int DEF_TX_CYCLES      = 3000;
    localparam int DEF_BLANK_CYCLES   = 15000;
    localparam int DEF_TIMEOUT_CYCLES = 140000;
    localparam int DEF_COUNT_WIDTH    = 20;

endpackage

// File: rtl/ping_echo_timer_sync.sv
// Brings the asynchronous echo comparator into clk_in and flags its rising edges.
// rise_out is high for the one cycle in which the synchronized level first reads 1.
module sync_edge_detect (
    input  logic clk_in,
    input  logic rst_in,
    input  logic async_in,
    output logic level_out,
    output logic rise_out
);

    logic sync1;
    logic sync2;
    logic hist;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign level_out = sync2;
    assign rise_out  = sync2 && !hist;

endmodule

// File: rtl/ping_echo_timer.sv
// One ping per trigger: transmit burst, receiver blanking, then listen for the echo
// rising edge and report time-of-flight in cycles, or flag a miss at the timeout.
module ping_echo_timer
    import ping_pkg::*;
#(
    parameter int TX_CYCLES      = DEF_TX_CYCLES,
    parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int COUNT_WIDTH    = DEF_COUNT_WIDTH
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   trigger_in,
    input  logic                   echo_in,
    output logic                   tx_out,
    output logic                   busy_out,
    output logic [COUNT_WIDTH-1:0] tof_out,
    output logic                   tof_valid_out,
    output logic                   timeout_out
);

    localparam logic [COUNT_WIDTH-1:0] TX_LAST      = COUNT_WIDTH'(TX_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] BLANK_LAST   = COUNT_WIDTH'(TX_CYCLES + BLANK_CYCLES - 1);
    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                 state;
    logic [COUNT_WIDTH-1:0] elapsed;
    logic                   echo_level;
    logic                   echo_rise;
    logic                   echo_hit;

    sync_edge_detect u_echo_sync (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .async_in  (echo_in),
        .level_out (echo_level),
        .rise_out  (echo_rise)
    );

    assign echo_hit = echo_rise && echo_level;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            elapsed       <= '0;
            tx_out        <= 1'b0;
            busy_out      <= 1'b0;
            tof_out       <= '0;
            tof_valid_out <= 1'b0;
            timeout_out   <= 1'b0;
        end else begin
            tof_valid_out <= 1'b0;
            timeout_out   <= 1'b0;
            if (state != IDLE) begin
                elapsed <= elapsed + COUNT_WIDTH'(1);
            end
            case (state)
                IDLE: begin
                    if (trigger_in) begin
                        state    <= TX;
                        elapsed  <= '0;
                        tx_out   <= 1'b1;
                        busy_out <= 1'b1;
                    end
                end
                TX: begin
                    if (elapsed == TX_LAST) begin
                        state  <= BLANK;
                        tx_out <= 1'b0;
                    end
                end
                BLANK: begin
                    if (elapsed == BLANK_LAST) begin
                        state <= LISTEN;
                    end
                end
                LISTEN: begin
                    // An echo on the final listening cycle takes priority over the miss.
                    if (echo_hit) begin
                        tof_out       <= elapsed;
                        tof_valid_out <= 1'b1;
                        state         <= IDLE;
                        busy_out      <= 1'b0;
                    end else if (elapsed == TIMEOUT_LAST) begin
                        timeout_out <= 1'b1;
                        state       <= IDLE;
                        busy_out    <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_out   <= 1'b0;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ping_echo_timer.sv
// Scoreboard bench for ping_echo_timer with short timing parameters (TX=4, BLANK=6, TIMEOUT=40).
`timescale 1ns/1ps
module tb_ping_echo_timer;

    localparam int CW = 20;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          trigger_in;
    logic          echo_in;
    logic          tx_out;
    logic          busy_out;
    logic [CW-1:0] tof_out;
    logic          tof_valid_out;
    logic          timeout_out;

    typedef struct packed {
        logic          is_timeout;
        logic [CW-1:0] tof;
    } evt_t;

    evt_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   el       = 0;
    int   tx_cnt   = 0;
    int   tx_base  = 0;

    ping_echo_timer #(
        .TX_CYCLES      (4),
        .BLANK_CYCLES   (6),
        .TIMEOUT_CYCLES (40),
        .COUNT_WIDTH    (CW)
    ) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .trigger_in    (trigger_in),
        .echo_in       (echo_in),
        .tx_out        (tx_out),
        .busy_out      (busy_out),
        .tof_out       (tof_out),
        .tof_valid_out (tof_valid_out),
        .timeout_out   (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic expect_evt(input bit is_to, input int tof);
        evt_t e;
        e.is_timeout = is_to;
        e.tof        = CW'(tof);
        exp_q.push_back(e);
    endtask

    // Leaves the bench at 1 ns after the edge that sampled the trigger (elapsed = 0).
    task automatic start_ping();
        @(posedge clk_in);
        #1 trigger_in = 1'b1;
        @(posedge clk_in);
        #1 trigger_in = 1'b0;
        el      = 0;
        tx_base = tx_cnt;
    endtask

    // Advance so the DUT's elapsed count equals k; inputs set now are sampled at elapsed=k.
    task automatic goto_el(input int k);
        if (k > el) begin
            repeat (k - el) @(posedge clk_in);
            #1;
        end
        el = k;
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while (busy_out && i < 200) begin
            @(posedge clk_in);
            #1;
            i++;
        end
        check(name, busy_out, 0);
        repeat (2) @(posedge clk_in);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            forever begin
                evt_t e;
                @(negedge clk_in);
                if (tx_out) tx_cnt++;
                if (tof_valid_out || timeout_out) begin
                    if (tof_valid_out && timeout_out) begin
                        check("both_pulses", 1, 0);
                    end else if (exp_q.size() == 0) begin
                        check("unexpected_event", tof_valid_out ? tof_out : 32'hFFFF_FFFF, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_is_timeout", timeout_out, e.is_timeout);
                        if (!e.is_timeout) check("tof_value", tof_out, e.tof);
                    end
                end
            end
        join_none

        rst_in     = 1'b1;
        trigger_in = 1'b0;
        echo_in    = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_tx", tx_out, 0);
        check("rst_busy", busy_out, 0);
        check("rst_tof", tof_out, 0);
        check("rst_tof_valid", tof_valid_out, 0);
        check("rst_timeout", timeout_out, 0);
        rst_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;

        // 1: basic echo, sampled high at elapsed 18 -> tof 20
        start_ping();
        check("t1_tx_first", tx_out, 1);
        check("t1_busy", busy_out, 1);
        goto_el(3);
        check("t1_tx_last", tx_out, 1);
        goto_el(4);
        check("t1_tx_off", tx_out, 0);
        check("t1_busy_blank", busy_out, 1);
        goto_el(18);
        echo_in = 1'b1;
        expect_evt(1'b0, 20);
        wait_idle("t1_idle");
        echo_in = 1'b0;
        check("t1_tx_len", tx_cnt - tx_base, 4);

        // 2: echo pulse inside TX/BLANK is ignored -> timeout, tof held
        start_ping();
        goto_el(2);
        echo_in = 1'b1;
        goto_el(5);
        echo_in = 1'b0;
        expect_evt(1'b1, 0);
        wait_idle("t2_idle");
        check("t2_tof_held", tof_out, 20);
        check("t2_tx_len", tx_cnt - tx_base, 4);

        // 3: level already high through LISTEN -> timeout; then fall/rise -> tof 17
        start_ping();
        goto_el(5);
        echo_in = 1'b1;
        expect_evt(1'b1, 0);
        wait_idle("t3a_idle");
        start_ping();
        goto_el(10);
        echo_in = 1'b0;
        goto_el(15);
        echo_in = 1'b1;
        expect_evt(1'b0, 17);
        wait_idle("t3b_idle");
        echo_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;

        // 4: triggers while busy and on the return-to-IDLE cycle are dropped
        start_ping();
        goto_el(7);
        trigger_in = 1'b1;
        goto_el(8);
        trigger_in = 1'b0;
        goto_el(20);
        echo_in = 1'b1;
        expect_evt(1'b0, 22);
        goto_el(22);
        trigger_in = 1'b1;
        goto_el(23);
        trigger_in = 1'b0;
        echo_in    = 1'b0;
        check("t4_idle_after", busy_out, 0);
        check("t4_tx_len", tx_cnt - tx_base, 4);
        begin
            int act;
            act = 0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk_in);
                #1;
                if (busy_out || tx_out) act++;
            end
            check("t4_no_retrigger", act, 0);
        end

        // 5: edge detected at elapsed 39 beats the timeout
        start_ping();
        goto_el(37);
        echo_in = 1'b1;
        expect_evt(1'b0, 39);
        wait_idle("t5_idle");
        echo_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;

        // 6: reset during TX, then a fresh ping
        start_ping();
        goto_el(2);
        rst_in = 1'b1;
        goto_el(3);
        rst_in = 1'b0;
        check("t6_tx_reset", tx_out, 0);
        check("t6_busy_reset", busy_out, 0);
        check("t6_tof_reset", tof_out, 0);
        check("t6_valid_reset", tof_valid_out, 0);
        repeat (3) @(posedge clk_in);
        #1;
        start_ping();
        check("t6_tx_restart", tx_out, 1);
        goto_el(12);
        echo_in = 1'b1;
        expect_evt(1'b0, 14);
        wait_idle("t6_idle");
        echo_in = 1'b0;
        check("t6_tx_len", tx_cnt - tx_base, 4);

        repeat (5) @(posedge clk_in);
        #1;
        check("events_pending", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
